iexecute: RTL and testbench
===========================

IEXECUTE -- requirements
Module: iexecute

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, which sets the datapath width.
REQ-002 The block SHALL have port clk, input, 1 bit: the pipeline clock, with all state updating on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: a synchronous, active-high reset.
REQ-004 The block SHALL have inputs RegWriteE, MemWriteE, JumpE, BranchE and ALUSrcE, each 1 bit: control signals from the ID/EX register.
REQ-005 The block SHALL have input ResultSrcE, 2 bits: writeback source select, passed through unchanged.
REQ-006 The block SHALL have input ALUControlE, 3 bits: the ALU operation select.
REQ-007 The block SHALL have input RdE, 5 bits: the destination register index.
REQ-008 The block SHALL have inputs PCE, RD1E, RD2E, ImmExtE and PCPlus4E, each XLEN bits: data from the ID/EX register.
REQ-009 The block SHALL have inputs ForwardAE and ForwardBE, each 2 bits: operand-forward selects driven by the hazard unit.
REQ-010 The block SHALL have input ResultW, XLEN bits: the writeback-stage result used for forwarding.
REQ-011 The block SHALL have output PCSrcE, 1 bit: combinational redirect to the fetch stage.
REQ-012 The block SHALL have output PCTargetE, XLEN bits: combinational branch/jump target.
REQ-013 The block SHALL have registered outputs RegWriteM and MemWriteM, each 1 bit.
REQ-014 The block SHALL have registered output ResultSrcM, 2 bits.
REQ-015 The block SHALL have registered output RdM, 5 bits.
REQ-016 The block SHALL have registered outputs ALUResultM, WriteDataM and PCPlus4M, each XLEN bits.

Function
REQ-017 The SrcA mux SHALL select on ForwardAE: 00 -> RD1E, 01 -> ResultW, 10 -> ALUResultM, 11 -> RD1E.
REQ-018 The WriteDataE mux SHALL select on ForwardBE with the same encoding as REQ-017, using RD2E in place of RD1E.
REQ-019 SrcB SHALL equal ImmExtE when ALUSrcE=1, otherwise WriteDataE.
REQ-020 The ALU SHALL implement, by ALUControlE:
- 000: add
- 001: sub
- 010: and
- 011: or
- 100: xor
- 101: slt, signed, result 1 or 0, zero-extended
- 110 and 111: result 0
REQ-021 All ALU arithmetic SHALL be modulo 2^XLEN, with carry/overflow discarded and no trap.
REQ-022 ZeroE SHALL be 1 exactly when the ALU result equals 0.
REQ-023 PCTargetE SHALL equal PCE + ImmExtE modulo 2^XLEN.
REQ-024 PCSrcE SHALL equal (BranchE & ZeroE) | JumpE, with zero cycles of latency.
REQ-025 On each rising clk edge with reset=0, the EX/MEM register SHALL capture RegWriteE, MemWriteE, ResultSrcE, RdE, the ALU result, WriteDataE and PCPlus4E into the corresponding M outputs, giving one cycle of latency.
REQ-026 The forwarding path from ALUResultM SHALL use the registered value from the previous instruction, never the current cycle's ALU result, so that no combinational loop exists.
REQ-027 Simultaneous JumpE=1 and BranchE=1 SHALL give PCSrcE=1.
REQ-028 A bubble (all control inputs 0) SHALL propagate as RegWriteM=0 and MemWriteM=0.

Reset
REQ-029 While reset=1 at a rising edge, every registered M output SHALL become 0.
REQ-030 Reset asserted mid-stream SHALL discard the in-flight instruction with no partial update.
REQ-031 Combinational outputs SHALL remain functions of their inputs while reset=1.
REQ-032 The first edge with reset=0 SHALL capture normally.

Structure
REQ-033 The ALUControl encodings and the Forward select encodings SHALL be defined as constants in the shared pipeline package.
REQ-034 The EX/MEM register SHALL be a sub-module named ex_mem.
REQ-035 The ALU SHALL remain inline in iexecute.

Verification
REQ-036 Add: RD1E=5, RD2E=7, ALUSrcE=0, ALUControlE=000, RdE=3, RegWriteE=1 -> after one edge ALUResultM=12, RdM=3, RegWriteM=1.
REQ-037 Immediate slt: RD1E=0xFFFFFFFF, ImmExtE=1, ALUSrcE=1, ALUControlE=101 -> ALUResultM=1; then RD1E=1 -> ALUResultM=0.
REQ-038 Branch taken/not taken: BranchE=1, RD1E=RD2E=9, ALUControlE=001, PCE=0x100, ImmExtE=0xFFFFFFF0 -> PCSrcE=1, PCTargetE=0xF0 in the same cycle; then RD2E=8 -> PCSrcE=0.
REQ-039 Forwarding: ALUResultM=0x20 from the prior instruction, ResultW=0x30, ForwardAE=10, ForwardBE=01, ALUControlE=000 -> ALUResultM=0x50 and WriteDataM=0x30 after the edge.
REQ-040 Reset mid-stream: with RegWriteE=1 and MemWriteE=1 presented, assert reset for one edge -> all M outputs are 0; the next edge captures normally.
REQ-041 Wrap: RD1E=0xFFFFFFFF, RD2E=1, add -> ALUResultM=0; JumpE=1 with BranchE=0 -> PCSrcE=1.

Source files
------------

// File: rtl/iexecute_pkg.sv
// Shared pipeline constants for the execute stage:
// ALU operation codes and operand-forward selects.
package iexecute_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/iexecute_ex_mem.sv
// EX/MEM pipeline register: captures execute results
// and pass-through control for the memory stage.
module ex_mem #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic [1:0]      ResultSrcE,
  input  logic [4:0]      RdE,
  input  logic [XLEN-1:0] ALUResultE,
  input  logic [XLEN-1:0] WriteDataE,
  input  logic [XLEN-1:0] PCPlus4E,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [4:0]      RdM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M
);

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      RdM        <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      RdM        <= RdE;
      ALUResultM <= ALUResultE;
      WriteDataM <= WriteDataE;
      PCPlus4M   <= PCPlus4E;
    end
  end

endmodule

// File: rtl/iexecute.sv
// Execute stage: operand forwarding, ALU, branch resolve
// and the EX/MEM register.
module iexecute
  import iexecute_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            JumpE,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic [1:0]      ResultSrcE,
  input  logic [2:0]      ALUControlE,
  input  logic [4:0]      RdE,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [4:0]      RdM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M
);

  logic [XLEN-1:0] w_srca;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_srcb;
  logic [XLEN-1:0] w_alu;
  logic            w_zero;
  logic            w_lt;

  // MEM forwarding uses the registered result, so no loop
  always_comb begin
    w_srca = RD1E;
    case (ForwardAE)
      FWD_WB:  w_srca = ResultW;
      FWD_MEM: w_srca = ALUResultM;
      default: w_srca = RD1E;
    endcase
  end

  always_comb begin
    w_wdata = RD2E;
    case (ForwardBE)
      FWD_WB:  w_wdata = ResultW;
      FWD_MEM: w_wdata = ALUResultM;
      default: w_wdata = RD2E;
    endcase
  end

  assign w_srcb = ALUSrcE ? ImmExtE : w_wdata;
  assign w_lt   = $signed(w_srca) < $signed(w_srcb);

  always_comb begin
    w_alu = '0;
    case (ALUControlE)
      ALU_ADD: w_alu = w_srca + w_srcb;
      ALU_SUB: w_alu = w_srca - w_srcb;
      ALU_AND: w_alu = w_srca & w_srcb;
      ALU_OR:  w_alu = w_srca | w_srcb;
      ALU_XOR: w_alu = w_srca ^ w_srcb;
      ALU_SLT: w_alu = {{(XLEN-1){1'b0}}, w_lt};
      default: w_alu = '0;
    endcase
  end

  assign w_zero    = (w_alu == '0);
  assign PCTargetE = PCE + ImmExtE;
  assign PCSrcE    = (BranchE & w_zero) | JumpE;

  ex_mem #(
    .XLEN(XLEN)
  ) u_ex_mem (
    .clk        (clk),
    .reset      (reset),
    .RegWriteE  (RegWriteE),
    .MemWriteE  (MemWriteE),
    .ResultSrcE (ResultSrcE),
    .RdE        (RdE),
    .ALUResultE (w_alu),
    .WriteDataE (w_wdata),
    .PCPlus4E   (PCPlus4E),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .RdM        (RdM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .PCPlus4M   (PCPlus4M)
  );

endmodule

// File: tb/tb_iexecute.sv
// Testbench for iexecute: directed vector table, reset
// sequences and randomized runs against a reference model.
module tb_iexecute;

  logic        clk;
  logic        reset;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [4:0]  RdE;
  logic [31:0] PCE, RD1E, RD2E, ImmExtE, PCPlus4E;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] m_alu;

  iexecute #(.XLEN(32)) dut (
    .clk(clk), .reset(reset),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUSrcE(ALUSrcE),
    .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
    .RdE(RdE), .PCE(PCE), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .RdM(RdM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        re, me, jmp, br, src;
    logic [1:0]  rs;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [31:0] pc, rd1, rd2, imm, pc4;
    logic [1:0]  fa, fb;
    logic [31:0] resw;
    logic        epc;
    logic [31:0] etgt, ealu, ewd;
  } vec_t;

  function automatic vec_t mk(
    logic re, logic me, logic jmp, logic br, logic src,
    logic [1:0] rs, logic [2:0] op, logic [4:0] rd,
    logic [31:0] pc, logic [31:0] rd1, logic [31:0] rd2,
    logic [31:0] imm, logic [31:0] pc4,
    logic [1:0] fa, logic [1:0] fb, logic [31:0] resw,
    logic epc, logic [31:0] etgt,
    logic [31:0] ealu, logic [31:0] ewd);
    vec_t v;
    v.re = re; v.me = me; v.jmp = jmp; v.br = br;
    v.src = src; v.rs = rs; v.op = op; v.rd = rd;
    v.pc = pc; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm;
    v.pc4 = pc4; v.fa = fa; v.fb = fb; v.resw = resw;
    v.epc = epc; v.etgt = etgt;
    v.ealu = ealu; v.ewd = ewd;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    RegWriteE = v.re; MemWriteE = v.me;
    JumpE = v.jmp; BranchE = v.br; ALUSrcE = v.src;
    ResultSrcE = v.rs; ALUControlE = v.op; RdE = v.rd;
    PCE = v.pc; RD1E = v.rd1; RD2E = v.rd2;
    ImmExtE = v.imm; PCPlus4E = v.pc4;
    ForwardAE = v.fa; ForwardBE = v.fb; ResultW = v.resw;
  endtask

  // Called #1 after a rising edge; ends #1 after the next.
  task automatic run_vec(string nm, vec_t v);
    drive(v);
    #3;
    chk({nm, ".pcsrc"}, 32'(PCSrcE), 32'(v.epc));
    chk({nm, ".tgt"}, PCTargetE, v.etgt);
    @(posedge clk);
    #1;
    chk({nm, ".alu"}, ALUResultM, v.ealu);
    chk({nm, ".wd"}, WriteDataM, v.ewd);
    chk({nm, ".rw"}, 32'(RegWriteM), 32'(v.re));
    chk({nm, ".mw"}, 32'(MemWriteM), 32'(v.me));
    chk({nm, ".rs"}, 32'(ResultSrcM), 32'(v.rs));
    chk({nm, ".rd"}, 32'(RdM), 32'(v.rd));
    chk({nm, ".pc4"}, PCPlus4M, v.pc4);
    m_alu = v.ealu;
  endtask

  task automatic chk_m_zero(string nm);
    chk({nm, ".rw"}, 32'(RegWriteM), 0);
    chk({nm, ".mw"}, 32'(MemWriteM), 0);
    chk({nm, ".rs"}, 32'(ResultSrcM), 0);
    chk({nm, ".rd"}, 32'(RdM), 0);
    chk({nm, ".alu"}, ALUResultM, 0);
    chk({nm, ".wd"}, WriteDataM, 0);
    chk({nm, ".pc4"}, PCPlus4M, 0);
  endtask

  // Reference model from the ISA-level meaning of each op
  function automatic logic [31:0] ref_alu(
    logic [2:0] op, logic [31:0] a, logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_fwd(
    logic [1:0] f, logic [31:0] rf, logic [31:0] w,
    logic [31:0] m);
    if (f == 2'd1) return w;
    if (f == 2'd2) return m;
    return rf;
  endfunction

  vec_t tbl[16];
  vec_t v;
  logic [31:0] a, wd, b;

  initial begin
    tbl[0]  = mk(1,0,0,0,0, 0,3'd0,3, 0,5,7,0,4,
                 0,0,0, 0,0,12,7);
    tbl[1]  = mk(1,0,0,0,1, 1,3'd5,4, 0,32'hFFFFFFFF,0,1,8,
                 0,0,0, 0,1,1,0);
    tbl[2]  = mk(1,0,0,0,1, 1,3'd5,4, 0,1,0,1,12,
                 0,0,0, 0,1,0,0);
    tbl[3]  = mk(0,0,0,1,0, 0,3'd1,0,
                 32'h100,9,9,32'hFFFFFFF0,32'h104,
                 0,0,0, 1,32'hF0,0,9);
    tbl[4]  = mk(0,0,0,1,0, 0,3'd1,0,
                 32'h100,9,8,32'hFFFFFFF0,32'h104,
                 0,0,0, 0,32'hF0,1,8);
    tbl[5]  = mk(1,1,0,0,0, 2,3'd0,7,
                 32'h200,32'h10,32'h10,8,32'h204,
                 0,0,0, 0,32'h208,32'h20,32'h10);
    tbl[6]  = mk(1,0,0,0,0, 0,3'd0,8,
                 0,32'hDEAD,32'hBEEF,0,4,
                 2,1,32'h30, 0,0,32'h50,32'h30);
    tbl[7]  = mk(1,0,1,0,0, 0,3'd0,9,
                 32'h40,32'hFFFFFFFF,1,32'hC,32'h44,
                 0,0,0, 1,32'h4C,0,1);
    tbl[8]  = mk(0,0,1,1,0, 0,3'd1,0, 0,3,1,4,4,
                 0,0,0, 1,4,2,1);
    tbl[9]  = mk(1,0,0,0,0, 3,3'd4,1,
                 0,32'hAAAA,32'h5555,0,4,
                 3,3,32'h77, 0,0,32'hFFFF,32'h5555);
    tbl[10] = mk(0,0,0,1,0, 0,3'd6,0,
                 0,32'hAAAA,32'h5555,0,4,
                 0,0,0, 1,0,0,32'h5555);
    tbl[11] = mk(1,0,0,0,0, 0,3'd7,2, 0,1,2,0,4,
                 0,0,0, 0,0,0,2);
    tbl[12] = mk(1,0,0,0,0, 0,3'd2,5,
                 0,32'hF0F0,32'hFF00,0,4,
                 0,0,0, 0,0,32'hF000,32'hFF00);
    tbl[13] = mk(1,0,0,0,1, 0,3'd3,6,
                 0,32'h0F00,32'h1234,32'hF0,4,
                 0,0,0, 0,32'hF0,32'h0FF0,32'h1234);
    tbl[14] = mk(0,0,0,0,0, 0,3'd0,0, 0,0,1,0,0,
                 2,0,0, 0,0,32'h0FF1,1);
    tbl[15] = mk(1,1,0,0,0, 1,3'd1,31,
                 0,0,1,0,32'hFFFFFFFC,
                 0,0,0, 0,0,32'hFFFFFFFF,1);

    reset = 1'b1;
    drive(tbl[0]);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_m_zero("rst0");
    reset = 1'b0;
    m_alu = 0;

    for (int i = 0; i < 16; i++)
      run_vec($sformatf("v%0d", i), tbl[i]);

    // Reset mid-stream with an active store presented
    v = mk(1,1,1,0,0, 2,3'd0,17, 32'h10,2,3,32'h20,32'h14,
           0,0,0, 1,32'h30,5,3);
    drive(v);
    reset = 1'b1;
    #3;
    chk("rstmid.pcsrc", 32'(PCSrcE), 1);
    chk("rstmid.tgt", PCTargetE, 32'h30);
    @(posedge clk);
    #1;
    chk_m_zero("rstmid");
    reset = 1'b0;
    m_alu = 0;
    run_vec("postrst", v);

    for (int i = 0; i < 300; i++) begin
      v.re = 1'($urandom); v.me = 1'($urandom);
      v.jmp = ($urandom_range(0, 3) == 0);
      v.br = 1'($urandom); v.src = 1'($urandom);
      v.rs = 2'($urandom); v.op = 3'($urandom);
      v.rd = 5'($urandom);
      v.pc = $urandom; v.imm = $urandom;
      v.pc4 = $urandom;
      v.rd1 = $urandom;
      v.rd2 = ($urandom_range(0, 3) == 0) ? v.rd1 : $urandom;
      if ($urandom_range(0, 7) == 0) v.rd1 = 32'h7FFFFFFF;
      if ($urandom_range(0, 7) == 0) v.rd2 = 32'h80000000;
      v.fa = 2'($urandom); v.fb = 2'($urandom);
      v.resw = $urandom;
      a  = ref_fwd(v.fa, v.rd1, v.resw, m_alu);
      wd = ref_fwd(v.fb, v.rd2, v.resw, m_alu);
      b  = v.src ? v.imm : wd;
      v.ealu = ref_alu(v.op, a, b);
      v.ewd  = wd;
      v.etgt = v.pc + v.imm;
      v.epc  = v.jmp || (v.br && v.ealu == 0);
      run_vec($sformatf("r%0d", i), v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
